nlc_nsec_mch: RTL

NLC_NSEC_MCH -- requirements
Module: nlc_nsec_mch

---
 rtl/nlc_nsec_mch.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/nlc_nsec_mch.sv
`default_nettype none
// ============================================================================
//  Module      : nlc_nsec_mch
//  Description : Multi-channel, multi-section polynomial non-linearity
//                corrector. Each incoming sample picks a section by comparing
//                it against per-section limits. It is normalised with that
//                section's mean and reciprocal standard deviation. It is then
//                evaluated by a Horner polynomial, one coefficient per cycle.
//                A one-deep pending slot absorbs a sample that arrives while
//                the engine is busy. Further samples are dropped, and the
//                sticky ovf flag records the drop.
//  Option      : define NLC_SATURATE_EN to clamp the output to DW bits
//                instead of wrapping it.
//  Revision    : 1.0 - initial release
// ============================================================================
module nlc_nsec_mch #(
   parameter int NUM_CH  = 2,
   parameter int NUM_SEC = 3,
   parameter int ORDER   = 7,
   parameter int DW      = 21,
   parameter int CW      = 32,
   parameter int FRAC    = 16,
   localparam int c_chw  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int c_aw   = $clog2(NUM_CH * NUM_SEC * (ORDER + 4))
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              srdyi,
   input  logic [DW-1:0]     x_adc,
   input  logic [c_chw-1:0]  ch_in,
   output logic              srdyo,
   output logic [DW-1:0]     x_lin,
   output logic [c_chw-1:0]  ch_out,
   output logic              busy,
   output logic              ovf,
   input  logic              cfg_we,
   input  logic [c_aw-1:0]   cfg_addr,
   input  logic [CW-1:0]     cfg_wdata
);

   localparam int c_nw    = ORDER + 4;
   localparam int c_depth = NUM_CH * NUM_SEC * c_nw;
   localparam int c_sw    = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
   localparam int c_kw    = $clog2(ORDER + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEL   = 3'd1,
      S_SCALE = 3'd2,
      S_HORN  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t r_state, w_state_nxt;

   // Coefficient store; deliberately not reset so calibration survives reset
   logic [CW-1:0] r_mem [c_depth];

   // Working registers of the sample in flight
   logic [DW-1:0]        r_x;
   logic [c_chw-1:0]     r_ch;
   logic [c_sw-1:0]      r_sec;
   logic [c_kw-1:0]      r_k;
   logic signed [CW-1:0] r_u;
   logic signed [CW-1:0] r_acc;

   // One-deep pending slot
   logic                 r_pend_v;
   logic [DW-1:0]        r_pend_x;
   logic [c_chw-1:0]     r_pend_ch;

   // Output registers
   logic                 r_srdyo;
   logic [DW-1:0]        r_x_lin;
   logic [c_chw-1:0]     r_ch_out;
   logic                 r_ovf;

   logic                     w_idle, w_start, w_load, w_drop;
   logic signed [CW-1:0]     w_x_ext;
   logic [c_sw-1:0]          w_sec;
   logic signed [CW-1:0]     w_nm, w_rs, w_ctop, w_ck, w_sum, w_u, w_acc_nxt, w_y;
   logic signed [2*CW-1:0]   w_p_scale, w_p_horn;
   logic [DW-1:0]            w_red;
   logic                     w_unused;

   // Word address of coefficient idx of section sec on channel ch
   function automatic logic [c_aw-1:0] f_addr(input logic [c_chw-1:0] ch,
                                               input int sec, input int idx);
      return c_aw'(int'(ch) * NUM_SEC * c_nw + sec * c_nw + idx);
   endfunction

   // Coefficient writes land on the next edge regardless of engine state
   always_ff @(posedge clk) begin
      if (cfg_we && (int'(cfg_addr) < c_depth))
         r_mem[cfg_addr] <= cfg_wdata;
   end

   assign w_idle  = (r_state == S_IDLE);
   assign w_start = w_idle && (r_pend_v || srdyi);
   // In IDLE a full slot is being consumed this cycle, so it counts as free
   assign w_load  = srdyi && (w_idle ? r_pend_v : !r_pend_v);
   assign w_drop  = srdyi && !w_idle && r_pend_v;

   assign w_x_ext = $signed({{(CW-DW){r_x[DW-1]}}, r_x});

   // Section select: first section whose lower limit the sample reaches
   always_comb begin
      w_sec = c_sw'(NUM_SEC - 1);
      for (int s = NUM_SEC - 2; s >= 0; s--) begin
         if (w_x_ext >= $signed(r_mem[f_addr(r_ch, s, ORDER + 3)]))
            w_sec = c_sw'(s);
      end
   end

   // Per-section operands, read at the moment they are used
   always_comb begin
      w_nm   = $signed(r_mem[f_addr(r_ch, int'(r_sec), ORDER + 1)]);
      w_rs   = $signed(r_mem[f_addr(r_ch, int'(r_sec), ORDER + 2)]);
      w_ctop = $signed(r_mem[f_addr(r_ch, int'(r_sec), ORDER)]);
      w_ck   = $signed(r_mem[f_addr(r_ch, int'(r_sec), int'(r_k))]);
   end

   // Normalisation and Horner step arithmetic with full-width products
   always_comb begin
      w_sum     = w_x_ext + w_nm;
      w_p_scale = $signed({{CW{w_sum[CW-1]}}, w_sum}) * $signed({{CW{w_rs[CW-1]}}, w_rs});
      w_u       = w_p_scale[FRAC+CW-1:FRAC];
      w_p_horn  = $signed({{CW{r_acc[CW-1]}}, r_acc}) * $signed({{CW{r_u[CW-1]}}, r_u});
      w_acc_nxt = w_p_horn[FRAC+CW-1:FRAC] + w_ck;
      w_y       = r_acc >>> FRAC;
   end

   // Reduce the integer part of the accumulator to the sample width
   always_comb begin
      w_red = w_y[DW-1:0];
`ifdef NLC_SATURATE_EN
      if (w_y[CW-1:DW-1] != {(CW-DW+1){w_y[CW-1]}})
         w_red = w_y[CW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
   end

   assign w_unused = ^{w_p_scale[2*CW-1:FRAC+CW], w_p_scale[FRAC-1:0],
                       w_p_horn[2*CW-1:FRAC+CW], w_p_horn[FRAC-1:0], w_y};

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_SEL;
         S_SEL:   w_state_nxt = S_SCALE;
         S_SCALE: w_state_nxt = S_HORN;
         S_HORN:  if (r_k == '0) w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath of the sample in flight; contents are don't-care while idle
   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               r_x  <= r_pend_v ? r_pend_x  : x_adc;
               r_ch <= r_pend_v ? r_pend_ch : ch_in;
            end
         end
         S_SEL:   r_sec <= w_sec;
         S_SCALE: begin
            r_u   <= w_u;
            r_acc <= w_ctop;
            r_k   <= c_kw'(ORDER - 1);
         end
         S_HORN: begin
            r_acc <= w_acc_nxt;
            r_k   <= r_k - 1'b1;
         end
         default: ;
      endcase
   end

   // Pending slot, overflow flag and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_v <= 1'b0;
         r_srdyo  <= 1'b0;
         r_x_lin  <= '0;
         r_ch_out <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_srdyo <= (r_state == S_OUT);
         if (w_load) begin
            r_pend_v  <= 1'b1;
            r_pend_x  <= x_adc;
            r_pend_ch <= ch_in;
         end else if (w_idle && r_pend_v) begin
            r_pend_v <= 1'b0;
         end
         if (w_drop)
            r_ovf <= 1'b1;
         if (r_state == S_OUT) begin
            r_x_lin  <= w_red;
            r_ch_out <= r_ch;
         end
      end
   end

   assign srdyo  = r_srdyo;
   assign x_lin  = r_x_lin;
   assign ch_out = r_ch_out;
   assign busy   = !w_idle;
   assign ovf    = r_ovf;

endmodule
`default_nettype wire
